addsub_pipe: RTL and testbench

Parametrised, pipelined two's-complement add/subtract unit with optional saturation and registered status flags. It is the pipelined successor to the single-cycle 16-bit adder/subtractor. It sits in the execute path and is fed by a valid/ready handshake; its output can be back-pressured by the writeback stage. The carry chain is split into SEG-bit segments, one segment per pipeline stage, to shorten the critical path at larger widths.

---
 rtl/addsub_pipe_if.sv | 29 ++
 rtl/addsub_pipe.sv | 149 ++++++++++++++
 tb/tb_addsub_pipe.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result handshake bundle for addsub_pipe.
//   master: issues operations (in_valid, a, b, op) and consumes results (out_ready).
//   slave : the arithmetic unit; returns in_ready, out_valid, sum and status flags.
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             ovfl;
  logic             cout;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sum, ovfl, cout, zero, neg
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sum, ovfl, cout, zero, neg
  );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement add/subtract with optional saturation.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous drop of every in-flight operation (overrides stall and acceptance)
//   bus   : addsub_pipe_if.slave -- in_valid/in_ready/a/b/op in,
//           out_valid/out_ready/sum/ovfl/cout/zero/neg out
// The carry chain is cut into SEG-bit segments; segment k is resolved and registered in
// stage k. A final output register applies saturation and derives the flags, so an
// operation accepted at edge t is presented after edge t+N (N = WIDTH/SEG).
module addsub_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  addsub_pipe_if.slave bus
);
  localparam int unsigned N = WIDTH / SEG;

  // Element k is the input of stage k; element N is the output of the last stage.
  logic [N:0][WIDTH-1:0] st_a;
  logic [N:0][WIDTH-1:0] st_bn;
  logic [N:0][WIDTH-1:0] st_sum;
  logic [N:0][1:0]       st_op;
  logic [N:0]            st_c;
  logic [N:0]            st_v;

  logic             out_valid_q;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_ovfl_q;
  logic             res_cout_q;
  logic             res_zero_q;
  logic             res_neg_q;

  logic stall;

  // Back-pressure freezes the whole pipeline; bubbles are not squeezed out.
  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Subtraction enters as a + ~b + 1.
  assign st_a[0]   = bus.a;
  assign st_bn[0]  = bus.op[0] ? ~bus.b : bus.b;
  assign st_sum[0] = '0;
  assign st_op[0]  = bus.op;
  assign st_c[0]   = bus.op[0];
  assign st_v[0]   = bus.in_valid && !stall;

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [SEG:0]     part;
    logic [WIDTH-1:0] nsum;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bn_q;
    logic [WIDTH-1:0] sum_q;
    logic [1:0]       op_q;
    logic             c_q;
    logic             v_q;

    assign part = {1'b0, st_a[k][k*SEG +: SEG]} + {1'b0, st_bn[k][k*SEG +: SEG]} +
                  {{SEG{1'b0}}, st_c[k]};

    always_comb begin
      nsum = st_sum[k];
      nsum[k*SEG +: SEG] = part[SEG-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        a_q   <= '0;
        bn_q  <= '0;
        sum_q <= '0;
        op_q  <= '0;
        c_q   <= 1'b0;
      end else begin
        if (flush) begin
          v_q <= 1'b0;
        end else if (!stall) begin
          v_q <= st_v[k];
        end
        if (!stall) begin
          a_q   <= st_a[k];
          bn_q  <= st_bn[k];
          sum_q <= nsum;
          op_q  <= st_op[k];
          c_q   <= part[SEG];
        end
      end
    end

    assign st_a[k+1]   = a_q;
    assign st_bn[k+1]  = bn_q;
    assign st_sum[k+1] = sum_q;
    assign st_op[k+1]  = op_q;
    assign st_c[k+1]   = c_q;
    assign st_v[k+1]   = v_q;
  end

  logic             a_msb;
  logic             b_msb;
  logic             raw_ovfl;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] fin_sum;

  assign a_msb    = st_a[N][WIDTH-1];
  assign b_msb    = st_bn[N][WIDTH-1];
  // Operands of equal sign producing a result of the other sign.
  assign raw_ovfl = (a_msb == b_msb) && (st_sum[N][WIDTH-1] != a_msb);
  // On overflow the true result has the sign of a, so clamp toward that end.
  assign sat_val  = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign fin_sum  = (st_op[N][1] && raw_ovfl) ? sat_val : st_sum[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_ovfl_q  <= 1'b0;
      res_cout_q  <= 1'b0;
      res_zero_q  <= 1'b0;
      res_neg_q   <= 1'b0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (!stall) begin
        out_valid_q <= st_v[N];
      end
      // Result registers change only when a real operation lands.
      if (!stall && st_v[N] && !flush) begin
        res_sum_q  <= fin_sum;
        res_ovfl_q <= raw_ovfl;
        res_cout_q <= st_c[N];
        res_zero_q <= (fin_sum == '0);
        res_neg_q  <= fin_sum[WIDTH-1];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = res_sum_q;
  assign bus.ovfl      = res_ovfl_q;
  assign bus.cout      = res_cout_q;
  assign bus.zero      = res_zero_q;
  assign bus.neg       = res_neg_q;

  // Only the MSBs and op[1] matter once the last segment is resolved.
  logic unused_final;
  assign unused_final = ^{st_a[N][WIDTH-2:0], st_bn[N][WIDTH-2:0], st_op[N][0]};
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: randomized and directed checks of addsub_pipe (WIDTH=16, SEG=4) against
// an integer-arithmetic reference model and a queue of expected results.
module tb_addsub_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(16)) bus ();

  addsub_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        ovfl;
    logic        cout;
    logic        zero;
    logic        neg;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  int   n_out = 0;
  res_t mon_act;
  res_t prev_res;
  logic prev_stall = 1'b0;

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] op);
    res_t        r;
    int          sa, sb, t;
    int unsigned ua, ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = a;
    ub = b;
    t  = op[0] ? sa - sb : sa + sb;
    r.ovfl = (t > 32767) || (t < -32768);
    r.cout = op[0] ? (ua >= ub) : ((ua + ub) > 32'd65535);
    if (op[1] && r.ovfl) r.sum = (t < 0) ? 16'h8000 : 16'h7FFF;
    else r.sum = t[15:0];
    r.zero = (r.sum == 16'h0000);
    r.neg  = r.sum[15];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rnd16();
    logic [15:0] corner [5];
    corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  // Scoreboard: inputs and outputs are stable at the falling edge, so the handshakes
  // seen here are the ones the next rising edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      mon_act = {bus.sum, bus.ovfl, bus.cout, bus.zero, bus.neg};
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(mon_act), 32'(prev_res));
      end
      if (bus.out_valid && !bus.out_ready) check("in_ready_stall", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: out_valid=1 sum=%0h with nothing outstanding", bus.sum);
        end else if (bus.out_ready) begin
          check("result", 32'(mon_act), 32'(exp_q.pop_front()));
          n_out++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready && !flush;
      prev_res   = mon_act;
      if (flush) exp_q.delete();
      else if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.op));
        n_acc++;
      end
    end
  end

  task automatic issue_one(input logic [15:0] ta, input logic [15:0] tb, input logic [1:0] top,
                           input logic [15:0] es, input logic eo, input logic ec,
                           input logic ez, input logic en);
    int lat;
    @(posedge clk); #1;
    bus.a = ta; bus.b = tb; bus.op = top; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("dir_sum", 32'(bus.sum), 32'(es));
    check("dir_ovfl", 32'(bus.ovfl), 32'(eo));
    check("dir_cout", 32'(bus.cout), 32'(ec));
    check("dir_zero", 32'(bus.zero), 32'(ez));
    check("dir_neg", 32'(bus.neg), 32'(en));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acc_base, cyc, stall_cnt;
    logic stall_done;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_flags", 32'({bus.ovfl, bus.cout, bus.zero, bus.neg}), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Literal expectations.
    issue_one(16'h1234, 16'h4321, 2'b00, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    issue_one(16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
    issue_one(16'h7FFF, 16'h0001, 2'b10, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
    issue_one(16'h8000, 16'h0001, 2'b11, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    issue_one(16'h8000, 16'h0001, 2'b01, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    issue_one(16'hFFFF, 16'hFFFE, 2'b01, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_one(16'h0001, 16'hFFFF, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = rnd16();
      bus.b         = rnd16();
      bus.op        = 2'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    // Eight back-to-back operations with a 3-cycle stall after the first result.
    base = n_out; acc_base = n_acc; cyc = 0; stall_cnt = 0; stall_done = 1'b0;
    while ((n_out - base) < 8 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      bus.in_valid = ((n_acc - acc_base) < 8);
      bus.a  = rnd16();
      bus.b  = rnd16();
      bus.op = 2'($urandom);
      if (bus.out_valid && !stall_done) begin
        if (stall_cnt < 3) begin
          bus.out_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.out_ready = 1'b1;
          stall_done = 1'b1;
        end
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    check("stall_accepted", 32'(n_acc - acc_base), 32'd8);
    check("stall_results", 32'(n_out - base), 32'd8);
    check("stall_cycles", 32'(stall_cnt), 32'd3);

    // Flush with three in flight and a fourth being accepted.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.a = rnd16(); bus.b = rnd16(); bus.op = 2'($urandom);
      flush = (i == 3);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("flush_no_out", 32'(bus.out_valid), 32'd0);
    end

    // Asynchronous reset with operations in flight.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.a = 16'h7FFF; bus.b = 16'h7FFF; bus.op = 2'b00;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_sum", 32'(bus.sum), 32'd0);
    check("arst_flags", 32'({bus.ovfl, bus.cout, bus.zero, bus.neg}), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("arst_no_out", 32'(bus.out_valid), 32'd0);
    end
    check("arst_sum_after", 32'(bus.sum), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
